// File: rtl/rr_arb4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// Also holds the combinational rotating-priority search used by the top.
package rr_arb4_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First set request at or above ptr, wrapping 3 -> 0; returns 0 when none is set.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] idx;
        logic             found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ptr + IDX_W'(k);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arb4_gnt_dec.sv
// 2:4 one-hot decoder with enable; drives the arbiter grant vector.
module gnt_dec
    import rr_arb4_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with a bounded hold time per grant.
// A grant always ends with at least one idle cycle before the next arbitration.
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_id,
    output logic               busy,
    output logic               preempt
);

    localparam logic [7:0] LAST_CNT = 8'(MAX_HOLD - 1);
    localparam logic [7:0] PRE_CNT  = 8'(MAX_HOLD - 2);

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       hold_cnt;
    logic [IDX_W-1:0] pick;
    logic             grant_end;

    always_comb begin
        pick      = rr_pick(req, ptr);
        grant_end = !en || !req[gnt_id] || (hold_cnt == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt_id   <= '0;
            preempt  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    preempt  <= 1'b0;
                    if (en && (req != '0)) begin
                        state  <= GRANT;
                        gnt_id <= pick;
                    end
                end
                GRANT: begin
                    if (grant_end) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                        preempt  <= 1'b0;
                        ptr      <= gnt_id + IDX_W'(1);
                    end else begin
                        hold_cnt <= hold_cnt + 8'd1;
                        // Registered pulse: raised on entry to the final allowed grant cycle.
                        preempt  <= (hold_cnt == PRE_CNT);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == GRANT);

    gnt_dec u_gnt_dec (
        .idx    (gnt_id),
        .en     (busy),
        .onehot (gnt)
    );

endmodule

// File: tb/tb_rr_arb4.sv
// Directed self-checking bench for rr_arb4 with MAX_HOLD=4.
module tb_rr_arb4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       preempt;

    int checks = 0;
    int errors = 0;

    // Observed bundle: {gnt[3:0], gnt_id[1:0], busy, preempt}
    logic [7:0] obs;
    logic [7:0] expv;

    rr_arb4 #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .preempt (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb obs = {gnt, gnt_id, busy, preempt};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req = 4'b1111;
        tick();
        expv = 8'b0000_00_0_0;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", obs, expv);
        end
        rst = 1'b0; req = 4'b0000;
        tick();
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL idle_no_req: got %b expected %b", obs, expv);
        end
    endtask

    task automatic test_single();
        en = 1'b1; req = 4'b0001;
        tick();
        expv = 8'b0001_00_1_0;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL single_grant: got %b expected %b", obs, expv);
        end
        req = 4'b0000;
        tick();
        expv = 8'b0000_00_0_0;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL single_release: got %b expected %b", obs, expv);
        end
        en = 1'b0; req = 4'b0010;
        tick();
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL en_low_blocks: got %b expected %b", gnt, 4'b0000);
        end
        req = 4'b0000; en = 1'b1;
    endtask

    task automatic test_rr_order();
        logic [3:0] bit_i;
        do_reset();
        req = 4'b1111; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit_i = 4'b0001 << i;
            tick();
            expv = {bit_i, 2'(i), 1'b1, 1'b0};
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL rr_grant%0d_c1: got %b expected %b", i, obs, expv);
            end
            // Bits for already-served requesters toggle mid-grant and must be ignored.
            req = req | 4'b0001;
            tick();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL rr_grant%0d_c2: got %b expected %b", i, obs, expv);
            end
            req = (req & ~bit_i) & 4'b1110;
            tick();
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL rr_gap%0d: got %b expected %b", i, gnt, 4'b0000);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_timeout();
        req = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            tick();
            expv = {4'b0100, 2'd2, 1'b1, (c == 4)};
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL timeout_cycle%0d: got %b expected %b", c, obs, expv);
            end
        end
        tick();
        expv = 8'b0000_10_0_0;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL timeout_gap: got %b expected %b", obs, expv);
        end
        tick();
        expv = 8'b0100_10_1_0;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL timeout_regrant: got %b expected %b", obs, expv);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_wrap();
        req = 4'b1000;
        tick();
        expv = 8'b1000_11_1_0;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL wrap_grant3: got %b expected %b", obs, expv);
        end
        req = 4'b0001;
        tick();
        req = 4'b1001;
        tick();
        expv = 8'b0001_00_1_0;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL wrap_to_0: got %b expected %b", obs, expv);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_abort();
        req = 4'b0100;
        tick();
        tick();
        expv = 8'b0100_10_1_0;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL abort_pre: got %b expected %b", obs, expv);
        end
        en = 1'b0;
        tick();
        checks++;
        if ({gnt, busy, preempt} !== 6'b0000_0_0) begin
            errors++;
            $display("FAIL abort_drop: got %b expected %b", {gnt, busy, preempt}, 6'b0000_0_0);
        end
        en = 1'b1; req = 4'b1111;
        tick();
        expv = 8'b1000_11_1_0;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL abort_ptr3: got %b expected %b", obs, expv);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        req = 4'b0100;
        tick();
        tick();
        expv = 8'b0100_10_1_0;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL rstmid_pre: got %b expected %b", obs, expv);
        end
        rst = 1'b1;
        tick();
        expv = 8'b0000_00_0_0;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL rstmid_clear: got %b expected %b", obs, expv);
        end
        rst = 1'b0; req = 4'b1111;
        tick();
        expv = 8'b0001_00_1_0;
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL rstmid_first_arb: got %b expected %b", obs, expv);
        end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = 4'b0000;
        test_reset();
        test_single();
        test_rr_order();
        test_timeout();
        test_wrap();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
